// File: rtl/item_spawner.sv
// item_spawner: picks a pseudo-random free cell for the next item.
// A 16-bit Galois LFSR proposes candidates. Each candidate is checked against
// the field border, then against a snapshot of the snake body taken when the
// request is accepted (one body entry per cycle). The first free candidate is
// committed. The request gives up after MAX_TRIES rejected candidates.
// All outputs are registered copies of the FSM state, so they trail the state
// register by one clock.
module item_spawner #(
    parameter int XSIZE     = 48,
    parameter int YSIZE     = 64,
    parameter int MAX_SIZE  = 20,
    parameter int MAX_TRIES = 64
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Req,
    input  logic [MAX_SIZE*6-1:0] i_Body_x,
    input  logic [MAX_SIZE*6-1:0] i_Body_y,
    input  logic [11:0]           i_Size,
    input  logic                  i_Seed_Ld,
    input  logic [15:0]           i_Seed,
    output logic [5:0]            o_Item_x,
    output logic [5:0]            o_Item_y,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Fail
);
    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [5:0]  X_LIMIT    = 6'(XSIZE - 1);
    localparam logic [5:0]  Y_LIMIT    = 6'(YSIZE - 1);
    localparam logic [11:0] SIZE_CAP   = 12'(MAX_SIZE);
    localparam logic [6:0]  TRY_LIMIT  = 7'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [15:0]           lfsr_q;
    logic [15:0]           lfsr_d;
    logic [MAX_SIZE*6-1:0] body_x_q;
    logic [MAX_SIZE*6-1:0] body_y_q;
    logic [11:0]           ent_q;
    logic [11:0]           ent_d;
    logic [6:0]            attempt_q;
    logic [6:0]            attempt_d;
    logic [4:0]            index_q;
    logic [5:0]            cand_x_q;
    logic [5:0]            cand_y_q;
    logic                  fail_q;

    logic [5:0]            draw_x;
    logic [5:0]            draw_y;
    logic [5:0]            scan_x;
    logic [5:0]            scan_y;
    logic                  draw_reject;
    logic                  scan_hit;
    logic                  scan_last;
    logic                  try_exhausted;

    // Candidate decode, border test, body compare and counter next values.
    always_comb begin
        lfsr_d        = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        draw_x        = lfsr_q[5:0];
        draw_y        = lfsr_q[11:6];
        draw_reject   = (draw_x == 6'd0) || (draw_x >= X_LIMIT) ||
                        (draw_y == 6'd0) || (draw_y >= Y_LIMIT);
        scan_x        = body_x_q[int'(index_q)*6 +: 6];
        scan_y        = body_y_q[int'(index_q)*6 +: 6];
        scan_hit      = (scan_x == cand_x_q) && (scan_y == cand_y_q);
        scan_last     = ({7'd0, index_q} == (ent_q - 12'd1));
        attempt_d     = attempt_q + 7'd1;
        try_exhausted = (attempt_d == TRY_LIMIT);
        ent_d         = (i_Size > SIZE_CAP) ? SIZE_CAP : i_Size;
    end

    // Spawn FSM with LFSR, body snapshot, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_RESET;
            body_x_q  <= '0;
            body_y_q  <= '0;
            ent_q     <= '0;
            attempt_q <= '0;
            index_q   <= '0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            fail_q    <= 1'b0;
            o_Item_x  <= 6'd12;
            o_Item_y  <= 6'd32;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Fail    <= 1'b0;
        end else begin
            o_Busy <= (state_q != S_IDLE);
            o_Done <= (state_q == S_DONE);
            o_Fail <= (state_q == S_DONE) && fail_q;
            // The item only moves on a successful spawn; a give-up keeps the old one.
            if ((state_q == S_DONE) && !fail_q) begin
                o_Item_x <= cand_x_q;
                o_Item_y <= cand_y_q;
            end

            case (state_q)
                S_IDLE: begin
                    // Seed loads before the request so both can share a cycle.
                    if (i_Seed_Ld) begin
                        lfsr_q <= (i_Seed == 16'h0000) ? LFSR_RESET : i_Seed;
                    end
                    if (i_Req) begin
                        body_x_q  <= i_Body_x;
                        body_y_q  <= i_Body_y;
                        ent_q     <= ent_d;
                        attempt_q <= '0;
                        index_q   <= '0;
                        fail_q    <= 1'b0;
                        state_q   <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    lfsr_q <= lfsr_d;
                    if (draw_reject) begin
                        attempt_q <= attempt_d;
                        if (try_exhausted) begin
                            fail_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cand_x_q <= draw_x;
                        cand_y_q <= draw_y;
                        index_q  <= '0;
                        state_q  <= (ent_q == 12'd0) ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        attempt_q <= attempt_d;
                        if (try_exhausted) begin
                            fail_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DRAW;
                        end
                    end else if (scan_last) begin
                        state_q <= S_DONE;
                    end else begin
                        index_q <= index_q + 5'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_item_spawner.sv
// tb_item_spawner: randomized scoreboard bench for item_spawner.
// Two instances share one stimulus stream: dut_a with the default attempt
// limit and dut_b with MAX_TRIES=1, so give-up behaviour is exercised often.
// A per-instance reference model walks the spawn rules attempt by attempt and
// pushes the expected item, fail flag and o_Done cycle into a queue; separate
// monitors pop and compare whenever o_Done is seen.
module tb_item_spawner;
    localparam int XS = 48;
    localparam int YS = 64;
    localparam int MS = 20;
    localparam int TIMEOUT = 3000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic            seed_ld = 1'b0;
    logic [15:0]     seed = 16'h0000;
    logic [11:0]     size = 12'd0;
    logic [MS*6-1:0] body_x = '0;
    logic [MS*6-1:0] body_y = '0;
    logic [5:0]      a_x, a_y, b_x, b_y;
    logic            a_busy, a_done, a_fail, b_busy, b_done, b_fail;

    always #5 clk = ~clk;

    item_spawner #(.XSIZE(XS), .YSIZE(YS), .MAX_SIZE(MS), .MAX_TRIES(64)) dut_a (
        .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_Body_x(body_x), .i_Body_y(body_y),
        .i_Size(size), .i_Seed_Ld(seed_ld), .i_Seed(seed),
        .o_Item_x(a_x), .o_Item_y(a_y), .o_Busy(a_busy), .o_Done(a_done), .o_Fail(a_fail)
    );

    item_spawner #(.XSIZE(XS), .YSIZE(YS), .MAX_SIZE(MS), .MAX_TRIES(1)) dut_b (
        .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_Body_x(body_x), .i_Body_y(body_y),
        .i_Size(size), .i_Seed_Ld(seed_ld), .i_Seed(seed),
        .o_Item_x(b_x), .o_Item_y(b_y), .o_Busy(b_busy), .o_Done(b_done), .o_Fail(b_fail)
    );

    typedef struct {
        int x;
        int y;
        int fail;
        int cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea;
    exp_t        eb;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [5:0]  bxa[MS];
    logic [5:0]  bya[MS];
    logic [15:0] m_lfsr[2];
    int          m_ix[2];
    int          m_iy[2];
    int          max_tries[2] = '{64, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference: try candidates in LFSR order, summing the cycle cost of each.
    task automatic model(input int d, input int e_cnt, output exp_t r);
        int cost = 0;
        int tries = 0;
        int k;
        bit fin = 1'b0;
        logic [5:0] cx, cy;
        r.fail = 0;
        while (!fin) begin
            cx = m_lfsr[d][5:0];
            cy = m_lfsr[d][11:6];
            m_lfsr[d] = lfsr_step(m_lfsr[d]);
            if (cx == 0 || cx >= XS - 1 || cy == 0 || cy >= YS - 1) begin
                cost += 1;
                tries++;
            end else begin
                k = -1;
                for (int i = 0; i < e_cnt; i++)
                    if (k < 0 && bxa[i] == cx && bya[i] == cy) k = i;
                if (k < 0) begin
                    cost += 1 + e_cnt;
                    m_ix[d] = cx;
                    m_iy[d] = cy;
                    fin = 1'b1;
                end else begin
                    cost += k + 2;
                    tries++;
                end
            end
            if (!fin && tries == max_tries[d]) begin
                r.fail = 1;
                fin = 1'b1;
            end
        end
        r.x = m_ix[d];
        r.y = m_iy[d];
        r.cyc = cost + 1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = 16'hACE1;
            m_ix[d] = 12;
            m_iy[d] = 32;
        end
    endtask

    task automatic check_reset_outputs();
        check("A_rst_item_x", a_x, 12);
        check("A_rst_item_y", a_y, 32);
        check("A_rst_busy", a_busy, 0);
        check("A_rst_done", a_done, 0);
        check("A_rst_fail", a_fail, 0);
        check("B_rst_item_x", b_x, 12);
        check("B_rst_item_y", b_y, 32);
        check("B_rst_busy", b_busy, 0);
        check("B_rst_done", b_done, 0);
        check("B_rst_fail", b_fail, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && t < TIMEOUT) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= TIMEOUT) begin
            check("done_timeout", t, 0);
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic clear_body();
        for (int i = 0; i < MS; i++) begin
            bxa[i] = 6'd0;
            bya[i] = 6'd0;
        end
    endtask

    task automatic drive_body();
        for (int i = 0; i < MS; i++) begin
            body_x[i*6 +: 6] = bxa[i];
            body_y[i*6 +: 6] = bya[i];
        end
    endtask

    task automatic load_seed(input logic [15:0] sd);
        wait_idle();
        seed = sd;
        seed_ld = 1'b1;
        @(posedge clk);
        #1;
        seed_ld = 1'b0;
        for (int d = 0; d < 2; d++) m_lfsr[d] = (sd == 16'h0000) ? 16'hACE1 : sd;
    endtask

    // One spawn request; hold>0 keeps i_Req and a stray seed load asserted while busy.
    task automatic request(input int sz, input bit ld, input logic [15:0] sd, input int hold);
        exp_t r;
        int e_cnt;
        wait_idle();
        drive_body();
        size = sz[11:0];
        seed = sd;
        seed_ld = ld;
        req = 1'b1;
        if (ld) for (int d = 0; d < 2; d++) m_lfsr[d] = (sd == 16'h0000) ? 16'hACE1 : sd;
        e_cnt = (sz > MS) ? MS : sz;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model(d, e_cnt, r);
            r.cyc += cyc;
            if (d == 0) qa.push_back(r);
            else qb.push_back(r);
        end
        seed_ld = 1'b0;
        if (hold > 0) begin
            seed = 16'h1234;
            seed_ld = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            seed_ld = 1'b0;
        end
        req = 1'b0;
        body_x = ~body_x;
        body_y = ~body_y;
        if (hold == 0) begin
            @(posedge clk);
            #1;
            check("A_busy_after_accept", a_busy, 1);
            check("B_busy_after_accept", b_busy, 1);
        end
    endtask

    // Monitor for dut_a.
    always @(posedge clk) begin
        #1;
        if (a_fail) check("A_fail_without_done", a_done, 1);
        if (a_done) begin
            if (qa.size() == 0) begin
                check("A_unexpected_done", 1, 0);
            end else begin
                ea = qa.pop_front();
                check("A_done_cycle", cyc, ea.cyc);
                check("A_item_x", a_x, ea.x);
                check("A_item_y", a_y, ea.y);
                check("A_fail", a_fail, ea.fail);
                $display("txn A: cycle %0d item=(%0d,%0d) fail=%0d", cyc, a_x, a_y, a_fail);
            end
        end
    end

    // Monitor for dut_b.
    always @(posedge clk) begin
        #1;
        if (b_fail) check("B_fail_without_done", b_done, 1);
        if (b_done) begin
            if (qb.size() == 0) begin
                check("B_unexpected_done", 1, 0);
            end else begin
                eb = qb.pop_front();
                check("B_done_cycle", cyc, eb.cyc);
                check("B_item_x", b_x, eb.x);
                check("B_item_y", b_y, eb.y);
                check("B_fail", b_fail, eb.fail);
                $display("txn B: cycle %0d item=(%0d,%0d) fail=%0d", cyc, b_x, b_y, b_fail);
            end
        end
    end

    initial begin
        int seen;
        int sz;
        int e_cnt;
        int idx;
        model_reset();
        clear_body();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Zero seed maps to the default seed; empty body -> first candidate commits.
        load_seed(16'h0000);
        request(0, 1'b0, 16'h0000, 0);
        // Seed 0545 loaded together with the request, empty body.
        request(0, 1'b1, 16'h0545, 0);
        // Same seed, first candidate sits on body entry 0.
        clear_body();
        bxa[0] = 6'd5;
        bya[0] = 6'd21;
        request(3, 1'b1, 16'h0545, 0);
        // Two border rejects; request and seed load held high while busy.
        clear_body();
        request(0, 1'b1, 16'h0870, 1);
        // Oversized length saturates to a full-depth scan.
        for (int i = 0; i < MS; i++) begin
            bxa[i] = 6'($urandom_range(1, 46));
            bya[i] = 6'($urandom_range(1, 62));
        end
        request(200, 1'b0, 16'h0000, 0);

        // Reset in the middle of a full-depth scan aborts without o_Done.
        wait_idle();
        for (int i = 0; i < MS; i++) begin
            bxa[i] = 6'(40 + (i % 7));
            bya[i] = 6'd2;
        end
        drive_body();
        size = 12'd200;
        seed = 16'h0545;
        seed_ld = 1'b1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        seed_ld = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        qa.delete();
        qb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen += int'(a_done) + int'(b_done);
        end
        check("no_done_after_abort", seen, 0);
        check("A_idle_after_abort", a_busy, 0);

        // Randomized traffic, sometimes planting the next candidate in the body.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < MS; i++) begin
                bxa[i] = 6'($urandom_range(0, 63));
                bya[i] = 6'($urandom_range(0, 63));
            end
            case ($urandom_range(0, 3))
                0:       sz = $urandom_range(0, 3);
                3:       sz = $urandom_range(0, 4095);
                default: sz = $urandom_range(0, MS);
            endcase
            if ($urandom_range(0, 9) == 0) load_seed(16'($urandom_range(0, 3) == 0 ? 0 : $urandom));
            e_cnt = (sz > MS) ? MS : sz;
            if (e_cnt > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, e_cnt - 1);
                bxa[idx] = m_lfsr[0][5:0];
                bya[idx] = m_lfsr[0][11:6];
                request(sz, 1'b0, 16'h0000, 0);
            end else begin
                request(sz, $urandom_range(0, 7) == 0, 16'($urandom), 0);
            end
        end
        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
